// File: rtl/ppu_bus_pkg.sv
// ---------------------------------------------------------------------------
// ppu_bus_pkg
// Shared definitions for the PPU video-memory bus responder:
//   - state_e     : responder FSM states
//   - MIR_*       : 2-bit nametable mirroring mode codes
//   - NT_BASE     : upper physical address bits of the nametable window
//   - mirror_map  : logical PPU address -> physical backing-memory address
// ---------------------------------------------------------------------------
package ppu_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_DRIVE,
        ST_WR_WAIT,
        ST_WR_REQ
    } state_e;

    localparam logic [1:0] MIR_VERT = 2'd0;
    localparam logic [1:0] MIR_HORZ = 2'd1;
    localparam logic [1:0] MIR_SCA  = 2'd2;
    localparam logic [1:0] MIR_SCB  = 2'd3;

    localparam logic [2:0] NT_BASE  = 3'b100;

    // The whole 2000-3FFF window folds onto two 1 KiB nametables; the
    // selected table replaces A13..A10, A9..A0 pass through untouched.
    function automatic logic [13:0] mirror_map(input logic [13:0] addr,
                                               input logic [1:0]  mode);
        logic nt;
        case (mode)
            MIR_VERT: nt = addr[10];
            MIR_HORZ: nt = addr[11];
            MIR_SCA:  nt = 1'b0;
            default:  nt = 1'b1;
        endcase
        return addr[13] ? {NT_BASE, nt, addr[9:0]} : addr;
    endfunction

endpackage

// File: rtl/ppu_vram_responder_if.sv
// ---------------------------------------------------------------------------
// ppu_vram_responder_if
// Request/acknowledge bus between the responder and the backing memory.
//   mem_req   : request pending, held until mem_ack
//   mem_we    : request is a write
//   mem_addr  : 14-bit physical address
//   mem_wdata : write data
//   mem_rdata : read data, valid in the mem_ack cycle
//   mem_ack   : request accepted/completed
// master = responder side, slave = memory side.
// ---------------------------------------------------------------------------
interface ppu_vram_responder_if;

    logic        mem_req;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/ppu_pad_sync.sv
// ---------------------------------------------------------------------------
// ppu_pad_sync
// N-stage flop synchroniser for an asynchronous pad signal or bus.
//   clk   : sampling clock
//   rst   : synchronous active-high reset, loads RST_VAL into every stage
//   d_i   : raw pad value
//   q_o   : value after STAGES flops
// ---------------------------------------------------------------------------
module ppu_pad_sync #(
    parameter int                 WIDTH   = 1,
    parameter int                 STAGES  = 2,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // NOTE: every stage is preset on reset, not just the last one, so the
    // inactive level is already flushed through the chain when reset drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= RST_VAL;
            end
        end else begin
            // NOTE: non-blocking assignments make each stage take the value
            // its predecessor held before this edge, forming a true shift chain.
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ppu_vram_responder.sv
// ---------------------------------------------------------------------------
// ppu_vram_responder
// Responder for the PPU video-memory bus. Oversamples the PPU pads,
// rebuilds the 14-bit address from ALE/AD/PA_hi, applies nametable
// mirroring and runs each /RD or /WR strobe as one request on the
// backing-memory bus, driving AD back to the PPU during reads.
//   CLK, RES          : clock, synchronous active-high reset
//   ALE, n_RD, n_WR   : PPU pad strobes (raw, asynchronous)
//   PA_hi, AD_in      : PPU address A13..A8, AD pad input
//   AD_out, AD_oe     : AD pad drive value and output enable
//   mirror_ld         : load new_mirror into the mirroring register
//   new_mirror        : mirroring mode code
//   mem               : backing-memory req/ack bus (master side)
//   busy              : FSM not idle
//   err               : one-cycle pulse on a protocol violation
// ---------------------------------------------------------------------------
module ppu_vram_responder
    import ppu_bus_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] MIRROR_RST  = MIR_VERT
) (
    input  logic                 CLK,
    input  logic                 RES,
    input  logic                 ALE,
    input  logic                 n_RD,
    input  logic                 n_WR,
    input  logic [5:0]           PA_hi,
    input  logic [7:0]           AD_in,
    output logic [7:0]           AD_out,
    output logic                 AD_oe,
    input  logic                 mirror_ld,
    input  logic [1:0]           new_mirror,
    ppu_vram_responder_if.master mem,
    output logic                 busy,
    output logic                 err
);

    // ---------------- pad synchronisers ----------------
    logic       ale_s;
    logic       n_rd_s;
    logic       n_wr_s;
    logic [7:0] ad_s;
    logic [5:0] pa_hi_s;

    ppu_pad_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ale (
        .clk(CLK), .rst(RES), .d_i(ALE), .q_o(ale_s)
    );
    ppu_pad_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
        .clk(CLK), .rst(RES), .d_i(n_RD), .q_o(n_rd_s)
    );
    ppu_pad_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wr (
        .clk(CLK), .rst(RES), .d_i(n_WR), .q_o(n_wr_s)
    );
    ppu_pad_sync #(.WIDTH(8), .STAGES(SYNC_STAGES), .RST_VAL(8'h00)) u_sync_ad (
        .clk(CLK), .rst(RES), .d_i(AD_in), .q_o(ad_s)
    );
    ppu_pad_sync #(.WIDTH(6), .STAGES(SYNC_STAGES), .RST_VAL(6'h00)) u_sync_pa (
        .clk(CLK), .rst(RES), .d_i(PA_hi), .q_o(pa_hi_s)
    );

    // ---------------- state ----------------
    state_e      state_q;
    logic        rd_prev_q;
    logic        wr_prev_q;
    logic [7:0]  lo_q;
    logic [1:0]  mirror_q;
    logic [7:0]  rd_data_q;
    logic        ad_oe_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [13:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        err_q;

    // ---------------- edge detection / address ----------------
    logic        rd_fall;
    logic        rd_rise;
    logic        wr_fall;
    logic        wr_rise;
    logic        stray_edge;
    logic [7:0]  lo_cur;
    logic [13:0] mapped_addr;

    assign rd_fall = rd_prev_q & ~n_rd_s;
    assign rd_rise = ~rd_prev_q & n_rd_s;
    assign wr_fall = wr_prev_q & ~n_wr_s;
    assign wr_rise = ~wr_prev_q & n_wr_s;

    // A new strobe while a transaction is still running is dropped and flagged.
    assign stray_edge = (state_q != ST_IDLE) && (rd_fall || wr_fall);

    // Transparent while ALE_s is high, like the external '373 it replaces.
    assign lo_cur      = ale_s ? ad_s : lo_q;
    assign mapped_addr = mirror_map({pa_hi_s, lo_cur}, mirror_q);

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q     <= ST_IDLE;
            rd_prev_q   <= 1'b1;
            wr_prev_q   <= 1'b1;
            lo_q        <= '0;
            mirror_q    <= MIRROR_RST;
            rd_data_q   <= '0;
            ad_oe_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rd_prev_q <= n_rd_s;
            wr_prev_q <= n_wr_s;
            if (ale_s) begin
                lo_q <= ad_s;
            end
            if (mirror_ld) begin
                mirror_q <= new_mirror;
            end

            // NOTE: later non-blocking assignments to err_q in the case below
            // override this default within the same edge.
            err_q <= stray_edge;

            case (state_q)
                ST_IDLE: begin
                    if (rd_fall) begin
                        // Read wins a simultaneous fall; the write is flagged.
                        state_q    <= ST_RD_REQ;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= mapped_addr;
                        err_q      <= wr_fall;
                    end else if (wr_fall) begin
                        state_q     <= ST_WR_WAIT;
                        mem_addr_q  <= mapped_addr;
                        mem_wdata_q <= ad_s;
                    end
                end

                ST_RD_REQ: begin
                    // The request is never withdrawn before ack, even if the
                    // PPU has already given up on the read.
                    if (mem.mem_ack) begin
                        mem_req_q <= 1'b0;
                        rd_data_q <= mem.mem_rdata;
                        if (!n_rd_s) begin
                            state_q <= ST_RD_DRIVE;
                            ad_oe_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            err_q   <= 1'b1;
                        end
                    end
                end

                ST_RD_DRIVE: begin
                    if (ale_s) begin
                        state_q <= ST_IDLE;
                        ad_oe_q <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (rd_rise) begin
                        state_q <= ST_IDLE;
                        ad_oe_q <= 1'b0;
                    end
                end

                ST_WR_WAIT: begin
                    // Keep overwriting so the last sample before /WR rises wins.
                    if (!n_wr_s) begin
                        mem_wdata_q <= ad_s;
                    end
                    if (wr_rise) begin
                        state_q   <= ST_WR_REQ;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                    end
                end

                ST_WR_REQ: begin
                    if (mem.mem_ack) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ALE while driving means the PPU is about to drive AD itself: release
    // the pad in the very cycle ALE_s is seen, ahead of the state change.
    assign AD_oe  = ad_oe_q & ~ale_s;
    assign AD_out = rd_data_q;

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign busy = (state_q != ST_IDLE);
    assign err  = err_q;

endmodule
